icache_controller: RTL and testbench



---
 rtl/icache_controller_pkg.sv | 21 ++
 rtl/icache_data_array.sv | 48 ++++
 rtl/icache_controller.sv | 126 ++++++++++++
 tb/tb_icache_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_controller_pkg.sv
// Shared definitions for the instruction cache: fill FSM encoding, default
// geometry and the fixed address-field constants.
package icache_controller_pkg;

    // Fill controller states
    typedef enum logic [1:0] {
        ICACHE_IDLE     = 2'd0,
        ICACHE_MEM_READ = 2'd1,
        ICACHE_UPDATE   = 2'd2
    } icache_state_e;

    // Default cache geometry
    localparam int DEF_NUM_SETS    = 8;
    localparam int DEF_BLOCK_WORDS = 4;

    // Fixed address geometry: 32-bit byte addresses, 32-bit instruction words
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

endpackage

// File: rtl/icache_data_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One asynchronous read port (lookup) and one synchronous write port (refill).
module icache_data_array
    import icache_controller_pkg::*;
#(
    parameter  int NUM_SETS    = DEF_NUM_SETS,
    parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter  int TAG_W       = 25,
    localparam int IDX         = $clog2(NUM_SETS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IDX-1:0]                      rd_idx,
    output logic                                rd_valid,
    output logic [TAG_W-1:0]                    rd_tag,
    output logic [BLOCK_WORDS-1:0][WORD_W-1:0]  rd_line,
    input  logic                                wr_en,
    input  logic [IDX-1:0]                      wr_idx,
    input  logic [TAG_W-1:0]                    wr_tag,
    input  logic [BLOCK_WORDS-1:0][WORD_W-1:0]  wr_line
);

    logic [NUM_SETS-1:0]                     valid;
    logic [TAG_W-1:0]                        tags  [NUM_SETS];
    logic [BLOCK_WORDS-1:0][WORD_W-1:0]      lines [NUM_SETS];

    // Valid bits: cleared by reset (which wins over a same-cycle refill)
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage: contents only matter once the valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = lines[rd_idx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache with block-fill controller. Hits return the
// word combinationally with busywait low; a miss stalls fetch, reads the whole
// block from instruction memory, installs it and then serves the hit.
module icache_controller
    import icache_controller_pkg::*;
#(
    parameter  int NUM_SETS    = DEF_NUM_SETS,
    parameter  int BLOCK_WORDS = DEF_BLOCK_WORDS,
    localparam int IDX         = $clog2(NUM_SETS),
    localparam int OFF         = $clog2(BLOCK_WORDS),
    localparam int TAG_W       = ADDR_W - BYTE_OFF_W - OFF - IDX,
    localparam int BLK_W       = ADDR_W - BYTE_OFF_W - OFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             address,
    input  logic                          read_en,
    output logic [WORD_W-1:0]             instruction,
    output logic                          busywait,
    output logic                          mem_read,
    output logic [BLK_W-1:0]              mem_address,
    input  logic [WORD_W*BLOCK_WORDS-1:0] mem_readdata,
    input  logic                          mem_busywait
);

    icache_state_e                      state;
    icache_state_e                      next_state;

    logic [OFF-1:0]                     offset;
    logic [IDX-1:0]                     index;
    logic [TAG_W-1:0]                   tag;
    logic [1:0]                         unused_byte_sel;

    logic                               line_valid;
    logic [TAG_W-1:0]                   line_tag;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] line_words;
    logic                               hit;

    logic [BLK_W-1:0]                   miss_addr;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] fill_buf;
    logic                               refill;

    // Address split; byte-select bits are irrelevant for word fetches
    assign offset          = address[OFF+1:2];
    assign index           = address[OFF+IDX+1:OFF+2];
    assign tag             = address[ADDR_W-1:OFF+IDX+2];
    assign unused_byte_sel = address[1:0];

    assign refill = (state == ICACHE_UPDATE);

    icache_data_array #(
        .NUM_SETS    (NUM_SETS),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_W       (TAG_W)
    ) u_data_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_line  (line_words),
        .wr_en    (refill),
        .wr_idx   (miss_addr[IDX-1:0]),
        .wr_tag   (miss_addr[BLK_W-1:IDX]),
        .wr_line  (fill_buf)
    );

    assign hit         = read_en & line_valid & (line_tag == tag);
    assign instruction = line_words[offset];

    // A miss raises the stall in the same cycle so IF/ID never latches a miss word
    assign busywait    = read_en & ((state != ICACHE_IDLE) | ~hit);

    // Memory request is a pure state decode, so it cannot glitch outside MEM_READ
    assign mem_read    = (state == ICACHE_MEM_READ);
    assign mem_address = miss_addr;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ICACHE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Miss address latch: the line being filled is frozen even if the PC moves
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr <= '0;
        end else if ((state == ICACHE_IDLE) && read_en && !hit) begin
            miss_addr <= {tag, index};
        end
    end

    // Fill buffer: captures the block in the cycle memory drops busywait
    always_ff @(posedge clk) begin
        if ((state == ICACHE_MEM_READ) && !mem_busywait) begin
            fill_buf <= mem_readdata;
        end
    end

    // Next-state logic for the fill controller
    always_comb begin
        next_state = state;
        case (state)
            ICACHE_IDLE: begin
                if (read_en && !hit) begin
                    next_state = ICACHE_MEM_READ;
                end
            end
            ICACHE_MEM_READ: begin
                if (!mem_busywait) begin
                    next_state = ICACHE_UPDATE;
                end
            end
            ICACHE_UPDATE: begin
                next_state = ICACHE_IDLE;
            end
            default: begin
                next_state = ICACHE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: directed scenarios with literal
// expectations followed by randomized fetch traffic checked every cycle
// against a transaction-level cache model.
module tb_icache_controller;

    localparam int BW = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   address;
    logic          read_en;
    logic [31:0]   instruction;
    logic          busywait;
    logic          mem_read;
    logic [27:0]   mem_address;
    logic [127:0]  mem_readdata;
    logic          mem_busywait;

    int errors = 0;
    int checks = 0;
    int lat    = 5;
    bit started = 0;

    icache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .read_en      (read_en),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Instruction memory contents: fixed function of block address and word
    function automatic logic [31:0] mem_word(input logic [27:0] blk, input int i);
        if (blk == 28'h4) return 32'h11 * (i + 1);
        return {blk[23:0], 8'(i)} ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [127:0] build_block(input logic [27:0] blk);
        logic [127:0] b;
        for (int i = 0; i < BW; i++) b[32*i +: 32] = mem_word(blk, i);
        return b;
    endfunction

    // Memory: holds busywait for lat cycles of an active request
    int mem_cnt = 0;
    always @(posedge clk) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
    assign mem_busywait = mem_read && (mem_cnt < lat);
    assign mem_readdata = build_block(mem_address);

    // Reference model: which block each set holds, plus the one pending fill
    bit          mvalid [8];
    logic [27:0] mblk   [8];
    bit          fill_active = 0;
    bit          mem_done    = 0;
    int          fill_cnt    = 0;
    logic [27:0] fill_blk    = '0;

    function automatic bit mhit(input logic [31:0] a);
        return mvalid[a[6:4]] && (mblk[a[6:4]] == a[31:4]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 8; s++) mvalid[s] <= 0;
            fill_active <= 0;
            mem_done    <= 0;
        end else if (!fill_active) begin
            if (read_en && !mhit(address)) begin
                fill_active <= 1;
                fill_blk    <= address[31:4];
                fill_cnt    <= 0;
                mem_done    <= 0;
            end
        end else if (!mem_done) begin
            if (fill_cnt == lat) mem_done <= 1;
            else fill_cnt <= fill_cnt + 1;
        end else begin
            mvalid[fill_blk[2:0]] <= 1;
            mblk[fill_blk[2:0]]   <= fill_blk;
            fill_active <= 0;
            mem_done    <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all meaningful outputs against the model
    always @(negedge clk) begin
        bit exp_mr, exp_bw;
        if (started && !rst) begin
            exp_mr = fill_active && !mem_done;
            exp_bw = read_en && (fill_active || !mhit(address));
            chk("mem_read", mem_read, exp_mr);
            chk("busywait", busywait, exp_bw);
            if (exp_mr) chk("mem_address", mem_address, fill_blk);
            if (read_en && !exp_bw)
                chk("instruction", instruction, mem_word(address[31:4], int'(address[3:2])));
        end
    end

    // Record the block address of every fill request that starts
    logic [27:0] fill_q[$];
    bit prev_mr = 0;
    always @(negedge clk) begin
        if (!rst && mem_read && !prev_mr) fill_q.push_back(mem_address);
        prev_mr <= mem_read;
    end

    // Count stalled cycles until busywait drops; ends at the negedge of the ready cycle
    task automatic run_to_ready(output int n);
        n = 0;
        @(negedge clk);
        while (busywait && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: busywait still %0b after %0d cycles", busywait, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [2:0]  idx;
        logic [24:0] tg;
        case ($urandom_range(0, 3))
            0: idx = 3'd0;
            1: idx = 3'd1;
            2: idx = 3'd4;
            default: idx = 3'd7;
        endcase
        case ($urandom_range(0, 3))
            0: tg = 25'h0;
            1: tg = 25'h1;
            2: tg = 25'h2;
            default: tg = 25'h1ABCDEF;
        endcase
        return {tg, idx, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        int n;
        rst = 1; read_en = 0; address = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        started = 1;

        // Reset state
        @(negedge clk);
        chk("reset_busywait", busywait, 0);
        chk("reset_mem_read", mem_read, 0);

        // Cold miss on 0x40 with a 5-cycle memory
        step();
        read_en = 1; address = 32'h40; fill_q.delete();
        run_to_ready(n);
        chk("cold_stall_cycles", n, 8);
        chk("cold_instruction", instruction, 32'h11);
        chk("cold_fill_count", fill_q.size(), 1);
        if (fill_q.size() > 0) chk("cold_mem_address", fill_q[0], 28'h4);

        // Spatial hit in the same line
        step();
        address = 32'h48;
        @(negedge clk);
        chk("spatial_busywait", busywait, 0);
        chk("spatial_instruction", instruction, 32'h33);
        chk("spatial_mem_read", mem_read, 0);

        // Conflict miss on the same index evicts the line
        step();
        address = 32'hC0; fill_q.delete();
        run_to_ready(n);
        chk("conflict_stall_cycles", n, 8);
        chk("conflict_fill_count", fill_q.size(), 1);
        if (fill_q.size() > 0) chk("conflict_mem_address", fill_q[0], 28'hC);
        step();
        address = 32'h40;
        @(negedge clk);
        chk("evicted_busywait", busywait, 1);
        run_to_ready(n);
        chk("refetch_instruction", instruction, 32'h11);

        // PC moves while a fill is in flight
        step();
        lat = 3; address = 32'h100; fill_q.delete();
        repeat (2) @(posedge clk);
        #1;
        address = 32'h200;
        run_to_ready(n);
        chk("midfill_fill_count", fill_q.size(), 2);
        if (fill_q.size() == 2) begin
            chk("midfill_first_block", fill_q[0], 28'h10);
            chk("midfill_second_block", fill_q[1], 28'h20);
        end
        chk("midfill_instruction", instruction, 32'hA5A5_0000 ^ 32'h2000);

        // Reset during MEM_READ abandons the fill and clears the cache
        step();
        lat = 6; address = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        step();
        rst = 0; address = 32'h48;
        @(negedge clk);
        chk("midreset_mem_read", mem_read, 0);
        chk("midreset_busywait", busywait, 1);
        run_to_ready(n);
        chk("postreset_instruction", instruction, 32'h33);

        // Idle fetch on an uncached address never starts a fill
        step();
        read_en = 0; address = 32'h7770;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busywait", busywait, 0);
            chk("idle_mem_read", mem_read, 0);
        end

        // Randomized traffic with varying memory latency and occasional reset
        for (int it = 0; it < 600; it++) begin
            step();
            if (!fill_active && $urandom_range(0, 7) == 0) lat = $urandom_range(0, 4);
            rst     = ($urandom_range(0, 99) == 0);
            read_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) address = rand_addr();
        end
        step();
        rst = 0; read_en = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
